counting_rr_sched: RTL and testbench
====================================

Name: counting_rr_sched

Overview:
Time-multiplexes one 1-2-3 run-detector engine between two symbol requesters.
- Holds a separate detector context per channel.
- Grants one symbol per cycle, round-robin.
- Reports each detected run as a tagged hit pulse and keeps a saturating hit count per channel.
- Sits between the symbol sources (2-bit num streams) and downstream statistics logic.
- Replaces two private counting instances with one shared, scheduled engine.

Parameters:
CNT_W, 8, width of each per-channel saturating hit counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  2  per-channel symbol valid, bit i = channel i
req_num  in  4  per-channel symbol, [1:0]=ch0, [3:2]=ch1
req_ready  out  2  per-channel accept; symbol consumed when valid&ready
clr  in  2  per-channel context/counter clear, one-cycle pulse
hit_valid  out  1  one-cycle pulse: a run completed
hit_ch  out  1  channel of the current hit
hit_cnt  out  2*CNT_W  saturating hit counts, [CNT_W-1:0]=ch0

Behaviour:
- Reset (rst_n=0 at clk edge):
  - Both contexts go to IDLE; counters = 0; stage register invalid.
  - hit_valid=0, hit_ch=0; round-robin pointer selects ch0 as first priority.
  - req_ready is 0 during reset.
- Detector per channel, states IDLE, S1, S2, S3 (encoding 0..3):
  - num=1: any state -> S1.
  - num=2: S1/S2 -> S2; else -> IDLE.
  - num=3: S2/S3 -> S3; else -> IDLE.
  - num=0: -> IDLE.
  - A hit occurs only on a transition S2->S3. Staying in S3 on repeated 3s gives no hit.
- Arbitration (cycle N):
  - Eligible channel i: req_valid[i]=1 and clr[i]=0.
  - One eligible: that channel is granted.
  - Both eligible: the pointer channel is granted; the pointer then moves to the other channel.
  - Pointer changes only on a grant made with both channels eligible.
  - req_ready is combinational: it is 1 only for the granted channel, so at most one bit is set.
- Pipeline:
  - Cycle N: the accepted {ch, num} is registered into the stage.
  - Cycle N+1: the context update is computed from the stage; hit_valid/hit_ch are registered.
  - Hit is visible at cycle N+2, i.e. 2-cycle latency from acceptance.
  - Counter increments on the same edge that raises hit_valid.
- Forwarding:
  - Back-to-back accepts on the same channel must see the updated context.
  - The stage's next-state result is forwarded as the current state of that channel.
  - No bubbles; throughput is 1 symbol/cycle.
- Counter: saturates at 2^CNT_W-1; further hits still pulse hit_valid but do not change the count.
- Clear:
  - clr[i] forces context i to IDLE and count i to 0 on the next edge.
  - clr[i] blocks the grant to channel i that cycle.
  - A stage entry for channel i that is in flight when clr[i] is asserted is discarded: no hit, no counter change, context stays IDLE.
  - clr on one channel does not disturb the other.
- Reset mid-run: all in-flight symbols are dropped; no hit is emitted after reset.

Decomposition:
- Shared package `counting_pkg` holds:
  - state encodings ST_IDLE/ST_S1/ST_S2/ST_S3;
  - symbol constants SYM_1/SYM_2/SYM_3;
  - a next-state/hit function reused by the original counting block.
- One sub-module is natural: `counting_rr_arb`, a 2-way round-robin arbiter (valid/eligible in, grant out, pointer register).
- Contexts, pipeline and counters stay in the top module.

Test Plan:
1. Ch0 only, 1,1,2,3,3,1,2,1,1,1,2,2,3,3,3,1 on consecutive cycles:
   - hits 2 cycles after the first 3 of each run (symbols 4 and 13);
   - hit_cnt[7:0]=2; ch1 count 0; req_ready=01 every cycle.
2. Both channels valid every cycle, ch0 stream 1,2,3 and ch1 stream 1,2,3:
   - grants alternate 0,1,0,1,0,1;
   - hits ch0 then ch1 on consecutive cycles;
   - both counts =1.
3. Ch1 with a 2 and a 3 issued on back-to-back cycles after a 1:
   - forwarding yields a hit without stall;
   - inserting 0 between 2 and 3 yields no hit.
4. Preload ch0 count to 255 (255 runs, CNT_W=8), one more run:
   - hit_valid pulses; count stays 255.
5. Ch0 sends 1,2,3 and clr[0] is asserted the cycle after the 3 is accepted:
   - no hit; count 0;
   - a following 3 produces no hit (context IDLE).
6. Assert rst_n=0 mid-stream on both channels for 1 cycle:
   - outputs/counts 0 next cycle, pointer at ch0;
   - a subsequent 2,3 without a leading 1 produces no hit.

Source files
------------

// File: rtl/counting_pkg.sv
// Shared encodings and the 1-2-3 run-detector step function used by every
// counting engine.
package counting_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_S1   = 2'd1;
    localparam logic [1:0] ST_S2   = 2'd2;
    localparam logic [1:0] ST_S3   = 2'd3;

    localparam logic [1:0] SYM_1 = 2'd1;
    localparam logic [1:0] SYM_2 = 2'd2;
    localparam logic [1:0] SYM_3 = 2'd3;

    typedef struct packed {
        logic [1:0] next_st;
        logic       hit;
    } det_res_t;

    // One symbol in flight between acceptance and the context update.
    typedef struct packed {
        logic       vld;
        logic       ch;
        logic [1:0] num;
    } stage_t;

    function automatic det_res_t det_step(input logic [1:0] cur, input logic [1:0] num);
        det_res_t r;
        r.next_st = ST_IDLE;
        r.hit     = 1'b0;
        case (num)
            SYM_1: r.next_st = ST_S1;
            SYM_2: if (cur == ST_S1 || cur == ST_S2) r.next_st = ST_S2;
            SYM_3: if (cur == ST_S2 || cur == ST_S3) r.next_st = ST_S3;
            default: r.next_st = ST_IDLE;
        endcase
        // Only the entry into S3 counts; lingering in S3 is not a new run.
        r.hit = (cur == ST_S2) && (r.next_st == ST_S3);
        return r;
    endfunction

endpackage

// File: rtl/counting_rr_arb.sv
// Two-way round-robin arbiter: a lone eligible channel always wins, a tie goes
// to the pointer channel and hands priority to the other one.
module counting_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        case (elig)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                grant = ptr_q ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/counting_rr_sched.sv
// One shared 1-2-3 run detector serving two symbol channels round-robin, with
// per-channel contexts, tagged hit pulses and saturating hit counters.
// Handshake: a symbol on channel i is consumed on a clock edge where
// req_valid[i] && req_ready[i]; req_ready is combinational and one-hot-or-zero.
module counting_rr_sched
    import counting_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    input  logic [3:0]         req_num,
    output logic [1:0]         req_ready,
    input  logic [1:0]         clr,
    output logic               hit_valid,
    output logic               hit_ch,
    output logic [2*CNT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       elig;
    logic [1:0]       grant;
    stage_t           stage_q, stage_d;
    logic [1:0]       ctx_q [2];
    logic [1:0]       ctx_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             hit_valid_q, hit_valid_d;
    logic             hit_ch_q, hit_ch_d;
    logic             stage_live;
    det_res_t         res;

    assign elig = req_valid & ~clr & {2{rst_n}};

    counting_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (elig),
        .grant (grant)
    );

    assign req_ready = grant;

    always_comb begin
        stage_d.vld = |grant;
        stage_d.ch  = grant[1];
        stage_d.num = grant[1] ? req_num[3:2] : req_num[1:0];
    end

    // The context is committed on the same edge that captures the next accepted
    // symbol, so a back-to-back symbol on the same channel reads the fresh state.
    always_comb begin
        ctx_d       = ctx_q;
        cnt_d       = cnt_q;
        hit_valid_d = 1'b0;
        hit_ch_d    = 1'b0;
        stage_live  = stage_q.vld && !clr[stage_q.ch];
        res         = det_step(ctx_q[stage_q.ch], stage_q.num);
        if (stage_live) begin
            ctx_d[stage_q.ch] = res.next_st;
            if (res.hit) begin
                hit_valid_d = 1'b1;
                hit_ch_d    = stage_q.ch;
                if (cnt_q[stage_q.ch] != CNT_MAX) begin
                    cnt_d[stage_q.ch] = cnt_q[stage_q.ch] + CNT_ONE;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (clr[i]) begin
                ctx_d[i] = ST_IDLE;
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q     <= '0;
            hit_valid_q <= 1'b0;
            hit_ch_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ctx_q[i] <= ST_IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            stage_q     <= stage_d;
            hit_valid_q <= hit_valid_d;
            hit_ch_q    <= hit_ch_d;
            ctx_q       <= ctx_d;
            cnt_q       <= cnt_d;
        end
    end

    assign hit_valid = hit_valid_q;
    assign hit_ch    = hit_ch_q;
    assign hit_cnt   = {cnt_q[1], cnt_q[0]};

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: tb/tb_counting_rr_sched.sv
// Directed bench for counting_rr_sched with a cycle-level reference model and
// hand-computed checkpoints for each scenario.
module tb_counting_rr_sched;

    localparam int CNT_W   = 8;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         req_valid = 2'b00;
    logic [3:0]         req_num = 4'h0;
    logic [1:0]         clr = 2'b00;
    logic [1:0]         req_ready;
    logic               hit_valid;
    logic               hit_ch;
    logic [2*CNT_W-1:0] hit_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // reference model state
    int m_ctx [2];
    int m_cnt [2];
    int m_ptr;
    bit m_stage_vld;
    int m_stage_ch;
    int m_stage_num;
    bit m_hv;
    int m_hch;
    int m_nx;
    logic [1:0] m_g;

    // observation logs
    int         seg_hits = 0;
    int         hit_cyc_q [$];
    int         hit_ch_q [$];
    logic [1:0] grant_log [$];
    logic [1:0] src0 [$];
    logic [1:0] src1 [$];

    counting_rr_sched #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_num   (req_num),
        .req_ready (req_ready),
        .clr       (clr),
        .hit_valid (hit_valid),
        .hit_ch    (hit_ch),
        .hit_cnt   (hit_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int run_next(input int s, input int num);
        if (num == 1) return 1;
        if (num == 2) return (s == 1 || s == 2) ? 2 : 0;
        if (num == 3) return (s == 2 || s == 3) ? 3 : 0;
        return 0;
    endfunction

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic [1:0] c,
                                             input int ptr, input logic rn);
        logic [1:0] e;
        e = v & ~c;
        if (!rn) return 2'b00;
        if (e == 2'b11) return (ptr == 1) ? 2'b10 : 2'b01;
        return e;
    endfunction

    // ---------------- reference model ----------------
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_ctx[i] = 0;
                m_cnt[i] = 0;
            end
            m_ptr = 0;
            m_stage_vld = 1'b0;
            m_hv = 1'b0;
            m_hch = 0;
        end else begin
            m_g = exp_grant(req_valid, clr, m_ptr, rst_n);
            m_hv = 1'b0;
            m_hch = 0;
            if (m_stage_vld && !clr[m_stage_ch]) begin
                m_nx = run_next(m_ctx[m_stage_ch], m_stage_num);
                if (m_ctx[m_stage_ch] == 2 && m_nx == 3) begin
                    m_hv = 1'b1;
                    m_hch = m_stage_ch;
                    if (m_cnt[m_stage_ch] < CNT_SAT) m_cnt[m_stage_ch] = m_cnt[m_stage_ch] + 1;
                end
                m_ctx[m_stage_ch] = m_nx;
            end
            for (int i = 0; i < 2; i++) begin
                if (clr[i]) begin
                    m_ctx[i] = 0;
                    m_cnt[i] = 0;
                end
            end
            m_stage_vld = (m_g != 2'b00);
            m_stage_ch  = m_g[1] ? 1 : 0;
            m_stage_num = m_g[1] ? int'(req_num[3:2]) : int'(req_num[1:0]);
            if ((req_valid & ~clr) == 2'b11) m_ptr = 1 - m_ptr;
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(exp_grant(req_valid, clr, m_ptr, rst_n)));
            check("hit_valid", 32'(hit_valid), 32'(m_hv));
            if (m_hv) check("hit_ch", 32'(hit_ch), 32'(m_hch));
            check("hit_cnt0", 32'(hit_cnt[CNT_W-1:0]), 32'(m_cnt[0]));
            check("hit_cnt1", 32'(hit_cnt[2*CNT_W-1:CNT_W]), 32'(m_cnt[1]));
            if (hit_valid === 1'b1) begin
                seg_hits++;
                hit_cyc_q.push_back(cyc);
                hit_ch_q.push_back(int'(hit_ch));
            end
            grant_log.push_back(req_ready);
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input logic [1:0] v, input logic [1:0] n0, input logic [1:0] n1,
                        input logic [1:0] c, input logic rn);
        req_valid = v;
        req_num   = {n1, n0};
        clr       = c;
        rst_n     = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(2'b00, 2'd0, 2'd0, 2'b00, 1'b1);
    endtask

    task automatic run_streams();
        int guard;
        logic [1:0] rdy;
        guard = 0;
        while ((src0.size() > 0 || src1.size() > 0) && guard < 1000) begin
            req_valid = {src1.size() > 0, src0.size() > 0};
            req_num   = {(src1.size() > 0) ? src1[0] : 2'd0, (src0.size() > 0) ? src0[0] : 2'd0};
            clr       = 2'b00;
            rst_n     = 1'b1;
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy[0] && src0.size() > 0) void'(src0.pop_front());
            if (rdy[1] && src1.size() > 0) void'(src1.pop_front());
            guard++;
        end
        check("stream_drained", 32'(guard < 1000), 32'd1);
    endtask

    task automatic seg_start();
        seg_hits = 0;
        hit_cyc_q.delete();
        hit_ch_q.delete();
        grant_log.delete();
    endtask

    // ---------------- directed scenarios ----------------
    logic [1:0] t1_seq [16] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd1,
                                2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
    int start_cyc;

    initial begin
        tick(2'b00, 2'd0, 2'd0, 2'b00, 1'b0);
        tick(2'b00, 2'd0, 2'd0, 2'b00, 1'b0);
        chk_en = 1'b1;
        check("rst_hit_valid", 32'(hit_valid), 32'd0);
        check("rst_hit_ch", 32'(hit_ch), 32'd0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);

        // 1: ch0 only, two runs at symbols 4 and 13
        seg_start();
        start_cyc = cyc;
        for (int j = 0; j < 16; j++) tick(2'b01, t1_seq[j], 2'd0, 2'b00, 1'b1);
        idle(3);
        check("t1_hits", 32'(seg_hits), 32'd2);
        if (hit_cyc_q.size() == 2) begin
            check("t1_hit0_lat", 32'(hit_cyc_q[0] - start_cyc), 32'd5);
            check("t1_hit1_lat", 32'(hit_cyc_q[1] - start_cyc), 32'd14);
        end
        check("t1_cnt0", 32'(hit_cnt[7:0]), 32'd2);
        check("t1_cnt1", 32'(hit_cnt[15:8]), 32'd0);

        // 2: both channels 1,2,3, alternating grants
        tick(2'b00, 2'd0, 2'd0, 2'b11, 1'b1);
        seg_start();
        src0 = '{2'd1, 2'd2, 2'd3};
        src1 = '{2'd1, 2'd2, 2'd3};
        run_streams();
        check("t2_grants", 32'(grant_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            check("t2_grant_k", 32'(grant_log[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
        idle(3);
        check("t2_hits", 32'(seg_hits), 32'd2);
        if (hit_ch_q.size() == 2) begin
            check("t2_hit_ch0", 32'(hit_ch_q[0]), 32'd0);
            check("t2_hit_ch1", 32'(hit_ch_q[1]), 32'd1);
            check("t2_hit_gap", 32'(hit_cyc_q[1] - hit_cyc_q[0]), 32'd1);
        end
        check("t2_cnts", 32'(hit_cnt), 32'h0101);

        // 3: ch1 back-to-back forwarding, then a 0 breaks the run
        seg_start();
        for (int j = 1; j <= 3; j++) tick(2'b10, 2'd0, 2'(j), 2'b00, 1'b1);
        idle(3);
        check("t3_fwd_hits", 32'(seg_hits), 32'd1);
        check("t3_cnt1", 32'(hit_cnt[15:8]), 32'd2);
        seg_start();
        tick(2'b10, 2'd0, 2'd1, 2'b00, 1'b1);
        tick(2'b10, 2'd0, 2'd2, 2'b00, 1'b1);
        tick(2'b10, 2'd0, 2'd0, 2'b00, 1'b1);
        tick(2'b10, 2'd0, 2'd3, 2'b00, 1'b1);
        idle(3);
        check("t3_gap_hits", 32'(seg_hits), 32'd0);
        check("t3_cnt1_hold", 32'(hit_cnt[15:8]), 32'd2);

        // 4: saturate ch0 at 255, one more run still pulses
        tick(2'b00, 2'd0, 2'd0, 2'b01, 1'b1);
        for (int r = 0; r < 255; r++)
            for (int j = 1; j <= 3; j++) tick(2'b01, 2'(j), 2'd0, 2'b00, 1'b1);
        idle(3);
        check("t4_cnt0_full", 32'(hit_cnt[7:0]), 32'd255);
        seg_start();
        for (int j = 1; j <= 3; j++) tick(2'b01, 2'(j), 2'd0, 2'b00, 1'b1);
        idle(3);
        check("t4_sat_pulse", 32'(seg_hits), 32'd1);
        check("t4_cnt0_sat", 32'(hit_cnt[7:0]), 32'd255);
        check("t4_cnt1", 32'(hit_cnt[15:8]), 32'd2);

        // 5: clr[0] while the final 3 is in flight
        seg_start();
        tick(2'b01, 2'd1, 2'd0, 2'b00, 1'b1);
        tick(2'b01, 2'd2, 2'd0, 2'b00, 1'b1);
        tick(2'b01, 2'd3, 2'd0, 2'b00, 1'b1);
        tick(2'b00, 2'd0, 2'd0, 2'b01, 1'b1);
        tick(2'b01, 2'd3, 2'd0, 2'b00, 1'b1);
        idle(3);
        check("t5_hits", 32'(seg_hits), 32'd0);
        check("t5_cnt0", 32'(hit_cnt[7:0]), 32'd0);
        check("t5_cnt1", 32'(hit_cnt[15:8]), 32'd2);

        // 6: one-cycle reset with a hit in flight
        seg_start();
        tick(2'b10, 2'd0, 2'd1, 2'b00, 1'b1);
        tick(2'b01, 2'd1, 2'd0, 2'b00, 1'b1);
        tick(2'b01, 2'd2, 2'd0, 2'b00, 1'b1);
        tick(2'b01, 2'd3, 2'd0, 2'b00, 1'b1);
        req_valid = 2'b11;
        req_num   = 4'b0101;
        clr       = 2'b00;
        rst_n     = 1'b0;
        @(negedge clk);
        check("t6_ready_in_rst", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("t6_hv_after_rst", 32'(hit_valid), 32'd0);
        check("t6_cnt_after_rst", 32'(hit_cnt), 32'd0);
        req_valid = 2'b11;
        req_num   = 4'b1010;
        rst_n     = 1'b1;
        @(negedge clk);
        check("t6_ptr_ch0", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        tick(2'b11, 2'd3, 2'd2, 2'b00, 1'b1);
        tick(2'b01, 2'd3, 2'd0, 2'b00, 1'b1);
        idle(3);
        check("t6_hits", 32'(seg_hits), 32'd0);
        check("t6_cnt_end", 32'(hit_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
